// File: rtl/lab71_soc_usb_rst_out.sv
// Avalon-MM output port for USB host controller control pins (e.g. MAX3421E RST).
// Software sets levels directly or launches a self-timed inverted pulse with busy/done status.
module lab71_soc_usb_rst_out #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_PULSE  = 3'd2;
    localparam logic [2:0] A_OUTSET = 3'd3;
    localparam logic [2:0] A_OUTCLR = 3'd4;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] mask, mask_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic             done, done_next;
    logic             aborting, aborting_next;
    logic [31:0]      rd_next;
    logic [WIDTH-1:0] out_next;

    logic             wr;
    logic             pulse_wr;
    logic [CNT_W-1:0] pulse_len;
    logic [WIDTH-1:0] pulse_mask;
    logic             unused_ok;

    assign wr         = chipselect & ~write_n;
    assign pulse_wr   = wr & (address == A_PULSE);
    assign pulse_len  = writedata[CNT_W-1:0];
    assign pulse_mask = writedata[16+WIDTH-1:16];
    assign unused_ok  = ^writedata;

    // Idle level register: direct write, bit set and bit clear.
    always_comb begin
        data_next = data_reg;
        if (wr) begin
            case (address)
                A_DATA:   data_next = writedata[WIDTH-1:0];
                A_OUTSET: data_next = data_reg | writedata[WIDTH-1:0];
                A_OUTCLR: data_next = data_reg & ~writedata[WIDTH-1:0];
                default:  data_next = data_reg;
            endcase
        end else begin
            data_next = data_reg;
        end
    end

    // Pulse FSM; an N==0 abort holds PULSE for one final cycle without raising DONE.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        mask_next     = mask;
        aborting_next = aborting;
        if (wr && (address == A_STATUS) && writedata[1]) begin
            done_next = 1'b0;
        end else begin
            done_next = done;
        end
        case (state)
            IDLE: begin
                if (pulse_wr && (pulse_len != CNT_ZERO)) begin
                    state_next    = PULSE;
                    cnt_next      = pulse_len;
                    mask_next     = pulse_mask;
                    aborting_next = 1'b0;
                end else begin
                    state_next = IDLE;
                end
            end
            PULSE: begin
                if (pulse_wr) begin
                    if (pulse_len != CNT_ZERO) begin
                        cnt_next      = pulse_len;
                        mask_next     = pulse_mask;
                        aborting_next = 1'b0;
                    end else begin
                        cnt_next      = CNT_ONE;
                        aborting_next = 1'b1;
                    end
                end else if (cnt == CNT_ONE) begin
                    state_next    = IDLE;
                    cnt_next      = CNT_ZERO;
                    aborting_next = 1'b0;
                    // Set has priority over a same-cycle W1C.
                    if (!aborting) begin
                        done_next = 1'b1;
                    end else begin
                        done_next = done_next;
                    end
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            default: begin
                state_next    = IDLE;
                cnt_next      = CNT_ZERO;
                aborting_next = 1'b0;
            end
        endcase
    end

    // Read mux and pin value; pins are computed from next-state so they settle right after the edge.
    always_comb begin
        rd_next = 32'd0;
        case (address)
            A_DATA:   rd_next[WIDTH-1:0] = data_reg;
            A_STATUS: rd_next[1:0]       = {done, (state == PULSE)};
            default:  rd_next            = 32'd0;
        endcase
        if (state_next == PULSE) begin
            out_next = data_next ^ mask_next;
        end else begin
            out_next = data_next;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= CNT_ZERO;
            mask     <= {WIDTH{1'b0}};
            data_reg <= RESET_VALUE;
            done     <= 1'b0;
            aborting <= 1'b0;
            readdata <= 32'd0;
            out_port <= RESET_VALUE;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            mask     <= mask_next;
            data_reg <= data_next;
            done     <= done_next;
            aborting <= aborting_next;
            readdata <= rd_next;
            out_port <= out_next;
        end
    end

endmodule
